// File: rtl/inst_queue.sv
// inst_queue: circular instruction buffer between I-cache response and decode.
// Latency: an entry written at edge N is presented at the head in cycle N+1; no fall-through.
// Backpressure: enq_ready_o = !full, which never depends on deq_ready_i; flush_i drops everything.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   flush_i                  redirect: discard all buffered entries in one cycle
//   enq_valid_i/enq_ready_o  fetch-side handshake carrying enq_pc_i, enq_inst_i
//   deq_valid_o/deq_ready_i  decode-side handshake carrying deq_pc_o, deq_inst_o
//   count_o                  occupied entries, 0..DEPTH
//   deq_is_ctrl_o            head is JAL/JALR/BRANCH (only when INST_QUEUE_PREDECODE_EN is defined)
//
// Optional feature macro: INST_QUEUE_PREDECODE_EN (per-entry control-flow predecode bit).
module inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       enq_valid_i,
    input  logic [31:0]                enq_pc_i,
    input  logic [31:0]                enq_inst_i,
    output logic                       enq_ready_o,
    output logic                       deq_valid_o,
    input  logic                       deq_ready_i,
    output logic [31:0]                deq_pc_o,
    output logic [31:0]                deq_inst_o,
`ifdef INST_QUEUE_PREDECODE_EN
    output logic                       deq_is_ctrl_o,
`endif
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
`ifdef INST_QUEUE_PREDECODE_EN
        logic        is_ctrl;
`endif
    } entry_t;

    // Storage is deliberately not reset: the pointers alone decide what is visible.
    entry_t mem [DEPTH];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          empty;
    logic          full;
    logic          enq_fire;
    logic          deq_fire;
    entry_t        head;
    entry_t        wr_entry;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

    assign enq_fire = enq_valid_i && !full && !flush_i;
    assign deq_fire = !empty && deq_ready_i && !flush_i;

`ifdef INST_QUEUE_PREDECODE_EN
    function automatic logic is_ctrl_op(input logic [6:0] opcode);
        logic r;
        r = 1'b0;
        case (opcode)
            7'b1101111,           // JAL
            7'b1100111,           // JALR
            7'b1100011: r = 1'b1; // BRANCH
            default:    r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    always_comb begin
        wr_entry      = '0;
        wr_entry.pc   = enq_pc_i;
        wr_entry.inst = enq_inst_i;
`ifdef INST_QUEUE_PREDECODE_EN
        wr_entry.is_ctrl = is_ctrl_op(enq_inst_i[6:0]);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (enq_fire && !rst_i) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    // Reset beats flush; flush beats any enqueue/dequeue in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Head outputs depend only on registered state; zeroed when empty so decode sees a NOP.
    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem[rd_idx];
        end
    end

    assign enq_ready_o = !full;
    assign deq_valid_o = !empty;
    assign deq_pc_o    = head.pc;
    assign deq_inst_o  = head.inst;
`ifdef INST_QUEUE_PREDECODE_EN
    assign deq_is_ctrl_o = head.is_ctrl;
`endif
    // Modulo-2*DEPTH subtraction falls out of the PW-bit width.
    assign count_o = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: bench for inst_queue against a queue-based reference model.
// Latency: model updates at each posedge, outputs compared at the following negedge.
// Backpressure: model accepts an enqueue only when it holds fewer than DEPTH entries.
module tb_inst_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          enq_valid_i = 1'b0;
    logic [31:0]   enq_pc_i = '0;
    logic [31:0]   enq_inst_i = '0;
    logic          enq_ready_o;
    logic          deq_valid_o;
    logic          deq_ready_i = 1'b0;
    logic [31:0]   deq_pc_o;
    logic [31:0]   deq_inst_o;
    logic [CW-1:0] count_o;
`ifdef INST_QUEUE_PREDECODE_EN
    logic          deq_is_ctrl_o;
`endif

    always #5 clk_i = ~clk_i;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .enq_valid_i  (enq_valid_i),
        .enq_pc_i     (enq_pc_i),
        .enq_inst_i   (enq_inst_i),
        .enq_ready_o  (enq_ready_o),
        .deq_valid_o  (deq_valid_o),
        .deq_ready_i  (deq_ready_i),
        .deq_pc_o     (deq_pc_o),
        .deq_inst_o   (deq_inst_o),
`ifdef INST_QUEUE_PREDECODE_EN
        .deq_is_ctrl_o(deq_is_ctrl_o),
`endif
        .count_o      (count_o)
    );

    int checks = 0;
    int fails  = 0;

    // Reference model: in-order list of {pc, inst} currently held.
    logic [63:0] mq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_ctrl_ref(input logic [31:0] inst);
        logic [6:0] op;
        op = inst[6:0];
        return (op == 7'h6F) || (op == 7'h67) || (op == 7'h63);
    endfunction

    task automatic check_outputs();
        logic        e;
        logic [63:0] h;
        e = (mq.size() == 0);
        h = e ? 64'h0 : mq[0];
        chk("deq_valid", 64'(deq_valid_o), 64'(!e));
        chk("enq_ready", 64'(enq_ready_o), 64'(mq.size() < DEPTH));
        chk("count",     64'(count_o),     64'(mq.size()));
        chk("deq_pc",    64'(deq_pc_o),    64'(h[63:32]));
        chk("deq_inst",  64'(deq_inst_o),  64'(h[31:0]));
`ifdef INST_QUEUE_PREDECODE_EN
        chk("deq_is_ctrl", 64'(deq_is_ctrl_o), 64'(e ? 1'b0 : is_ctrl_ref(h[31:0])));
`endif
    endtask

    // One clock: drive at negedge, update the model at posedge, compare at next negedge.
    task automatic cycle(input logic r, input logic f, input logic ev,
                         input logic [31:0] pc, input logic [31:0] inst, input logic dr);
        logic can_enq;
        rst_i       = r;
        flush_i     = f;
        enq_valid_i = ev;
        enq_pc_i    = pc;
        enq_inst_i  = inst;
        deq_ready_i = dr;
        @(posedge clk_i);
        can_enq = (mq.size() < DEPTH);
        if (r || f) begin
            mq.delete();
        end else begin
            if (dr && mq.size() > 0) void'(mq.pop_front());
            if (ev && can_enq) mq.push_back({pc, inst});
        end
        @(negedge clk_i);
        check_outputs();
    endtask

    logic [31:0] ops [4];
    logic [31:0] ctrl_insts [4];

    initial begin
        logic [31:0] rinst;
        logic [31:0] rpc;
        ops[0] = 32'h6F; ops[1] = 32'h67; ops[2] = 32'h63; ops[3] = 32'h13;
        ctrl_insts[0] = 32'h0000006F; ctrl_insts[1] = 32'h00008067;
        ctrl_insts[2] = 32'h00000063; ctrl_insts[3] = 32'h00000013;
        @(negedge clk_i);

        // Reset held two cycles, then idle.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 1, 32'hDEAD, 32'hBEEF, 1);
        cycle(0, 0, 0, 0, 0, 0);

        // Fill to full, attempt a fifth enqueue, then drain.
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 32'(4 * k), 32'h00100093 + 32'(k), 0);
        cycle(0, 0, 1, 32'h10, 32'h00100097, 0);
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 0, 1);

        // Streaming: one in, one out each cycle, pointers wrap several times.
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, 32'h200 + 32'(4 * i), $urandom, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // Flush with traffic present on both sides.
        for (int k = 0; k < 3; k++) cycle(0, 0, 1, 32'h20 + 32'(4 * k), $urandom, 0);
        cycle(0, 1, 1, 32'h40, 32'h00000013, 1);
        cycle(0, 0, 1, 32'h100, 32'h00A00113, 0);
        cycle(0, 0, 0, 0, 0, 1);

        // Full with dequeue: enqueue blocked, held entry accepted next cycle.
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 32'h300 + 32'(4 * k), $urandom, 0);
        cycle(0, 0, 1, 32'h310, 32'h12345678, 1);
        cycle(0, 0, 1, 32'h310, 32'h12345678, 0);
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 0, 1);

        // Predecode opcodes (the bit is only compared when the feature is built in).
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 32'h400 + 32'(4 * k), ctrl_insts[k], 0);
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 0, 1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            rinst = $urandom;
            rinst[6:0] = ops[$urandom_range(0, 3)][6:0];
            rpc = $urandom;
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 5),
                  ($urandom_range(0, 3) != 0), rpc, rinst, ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction buffer between the fetch stage and decode. It captures each instruction word returned from the I-cache, together with its PC, into a small circular FIFO and presents them to decode over a valid/ready handshake. This decouples I-cache response timing from decode stalls. A redirect flush discards every buffered entry in one cycle, so no wrong-path instruction reaches decode after a branch or jump.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- rst_i  input  1  reset, synchronous, active-high.
- flush_i  input  1  redirect/flush; discards all entries.
- enq_valid_i  input  1  fetch presents an instruction (I-cache response valid).
- enq_pc_i  input  32  PC of the presented instruction.
- enq_inst_i  input  32  instruction word.
- enq_ready_o  output  1  queue can accept an entry this cycle.
- deq_valid_o  output  1  head entry valid for decode.
- deq_ready_i  input  1  decode consumes the head this cycle.
- deq_pc_o  output  32  head PC.
- deq_inst_o  output  32  head instruction.
- count_o  output  $clog2(DEPTH)+1  number of occupied entries.
- deq_is_ctrl_o  output  1  head is a control-flow instruction (only with INST_QUEUE_PREDECODE_EN).

## Operation
- Storage: DEPTH entries, each holding {pc, inst}, plus is_ctrl under the macro. Entries are not reset.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and wrap bits differ.
- enq_ready_o = !full. It never depends on deq_ready_i; there is no combinational ready path.
- deq_valid_o = !empty.
  - deq_pc_o and deq_inst_o show the head entry when valid.
  - When empty, both are forced to 32'h0. Decode treats 0 as NOP.
- Enqueue fire = enq_valid_i & enq_ready_o & !flush_i. Write at wr_ptr, then wr_ptr += 1 with modulo-2·DEPTH wrap.
- Dequeue fire = deq_valid_o & deq_ready_i & !flush_i. Then rd_ptr += 1.
- Simultaneous enqueue and dequeue: both occur and count is unchanged.
  - Full: enqueue is blocked by enq_ready_o=0; dequeue proceeds.
  - Empty: enqueue only; no fall-through to the output.
- count_o = wr_ptr − rd_ptr, taken modulo 2·DEPTH. It ranges over 0..DEPTH.
- Flush: rd_ptr <= wr_ptr. Flush overrides any enqueue or dequeue in the same cycle, and the enq data that cycle is dropped.
- Reset: wr_ptr = rd_ptr = 0. Reset takes priority over flush.
- Fetch is responsible for holding enq data while enq_valid_i=1 and enq_ready_o=0. Dropped responses are fetch's concern; the queue never overwrites an occupied entry.

## Timing
- All outputs are registered or derived purely from registered state. No input-to-output combinational path.
- Reset values, in the cycle after rst_i is sampled high:
  - deq_valid_o=0, enq_ready_o=1, count_o=0.
  - deq_pc_o=0, deq_inst_o=0, deq_is_ctrl_o=0.
- Latency: an entry enqueued at edge N is visible at the head (deq_valid_o=1) after edge N, i.e. in cycle N+1. Minimum 1 cycle.
- Throughput: one enqueue and one dequeue per cycle, sustained.
- Flush at edge N: deq_valid_o=0 and count_o=0 in cycle N+1. Enqueue is accepted again from cycle N+1.
- Reset mid-operation is identical in effect to a flush plus pointer clear. Stored data is stale but unobservable.

## Configuration
- Macro: INST_QUEUE_PREDECODE_EN.
- Defined:
  - Each entry stores an is_ctrl bit, computed at enqueue from enq_inst_i[6:0].
  - is_ctrl is 1 for opcodes 7'b1101111 (JAL), 7'b1100111 (JALR) and 7'b1100011 (BRANCH); 0 otherwise.
  - deq_is_ctrl_o shows the head's bit, and is 0 when empty.
- Undefined: the deq_is_ctrl_o port and the per-entry bit do not exist. All other behaviour is identical.

## Test plan
- Reset/idle: assert rst_i 2 cycles, then release -> deq_valid_o=0, enq_ready_o=1, count_o=0, deq_inst_o=0.
- Fill and drain:
  - Stimulus: deq_ready_i=0; enqueue pc 0x0,0x4,0x8,0xC with inst 0x00100093+k.
  - Required: after the 4th, count_o=4 and enq_ready_o=0; a 5th enq_valid_i is not accepted.
  - Then deq_ready_i=1: heads appear in order 0x0..0xC, then deq_valid_o=0.
- Streaming: enq_valid_i=1 and deq_ready_i=1 every cycle for 20 cycles with PC stepping by 4 -> count_o holds at 1, every PC appears exactly once in order, and pointers wrap cleanly past DEPTH.
- Flush with traffic:
  - Stimulus: 3 entries queued; flush_i=1 while enq_valid_i=1 (pc 0x40) and deq_ready_i=1.
  - Required: next cycle count_o=0 and deq_valid_o=0; pc 0x40 never appears.
  - Then enqueue pc 0x100: it is the next head.
- Full with dequeue: full queue, enq_valid_i=1 and deq_ready_i=1 -> dequeue only, count_o=DEPTH−1, enq_ready_o=1 next cycle; the held enq entry is accepted in the following cycle.
- Predecode (macro on): enqueue 0x0000006F, 0x00008067, 0x00000063, 0x00000013 -> deq_is_ctrl_o = 1,1,1,0 in order.
